// File: rtl/char_out_if.sv
// Character-out strobe bus between the core and its output peripheral.
// The core drives a one-cycle out_en pulse with the byte on out_data; there is no backpressure.
interface char_out_if;
    logic       out_en;
    logic [7:0] out_data;

    modport master (output out_en, output out_data);
    modport slave  (input  out_en, input  out_data);
endinterface

// File: rtl/char_out_uart.sv
// Character-out UART: queues bytes strobed by the core in a small FIFO and
// shifts them out as 8N1 frames on tx. Bytes that arrive while the FIFO is full are dropped.
//
// state | meaning
// IDLE  | line high; pops the FIFO head whenever the FIFO is non-empty
// START | start bit (low) for CLKS_PER_BIT cycles
// DATA  | eight data bits, LSB first, CLKS_PER_BIT cycles each
// STOP  | stop bit (high) for CLKS_PER_BIT cycles
module char_out_uart #(
    parameter  int CLKS_PER_BIT = 434,
    parameter  int FIFO_DEPTH   = 16,
    localparam int FIFO_AW      = $clog2(FIFO_DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    char_out_if.slave        core,
    output logic             tx,
    output logic             busy,
    output logic             overflow,
    output logic [FIFO_AW:0] fifo_count
);

    localparam int                BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0]     BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0]  DEPTH_V   = (FIFO_AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state, state_d;
    logic [BW-1:0]        baud, baud_d;
    logic [2:0]           bit_idx, bit_idx_d;
    logic [7:0]           shreg, shreg_d;
    logic                 tx_d;
    logic                 baud_end;

    logic [7:0]           mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
    logic                 push, pop;

    assign baud_end = (baud == BAUD_LAST);

    // A pop on the same edge frees the slot, so a full FIFO can still accept that byte.
    assign push = core.out_en && ((fifo_count != DEPTH_V) || pop);

    assign busy = (state != IDLE) || (fifo_count != '0);

    always_comb begin
        state_d   = state;
        baud_d    = baud;
        bit_idx_d = bit_idx;
        shreg_d   = shreg;
        tx_d      = tx;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                tx_d      = 1'b1;
                baud_d    = '0;
                bit_idx_d = '0;
                if (fifo_count != '0) begin
                    pop     = 1'b1;
                    shreg_d = mem[rd_ptr];
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                    tx_d      = shreg[0];
                end else begin
                    baud_d = baud + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_idx == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx + 1'b1;
                        shreg_d   = shreg >> 1;
                        tx_d      = shreg[1];
                    end
                end else begin
                    baud_d = baud + 1'b1;
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                baud_d  = '0;
            end
        endcase
    end

    // tx is registered with the state so the line never glitches.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_d;
            baud    <= baud_d;
            bit_idx <= bit_idx_d;
            shreg   <= shreg_d;
            tx      <= tx_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (core.out_en && !push)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= core.out_data;
    end

endmodule

// File: tb/tb_char_out_uart.sv
// Bench for char_out_uart at CLKS_PER_BIT=4, FIFO_DEPTH=4: expected bytes are queued when
// driven and compared against frames decoded from tx; timing and FIFO flags are checked directly.
module tb_char_out_uart;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          tx, busy, overflow;
    logic [AW:0]   fifo_count;

    char_out_if core_bus ();

    char_out_uart #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .core       (core_bus.slave),
        .tx         (tx),
        .busy       (busy),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    always #5 clock = ~clock;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    int         frames   = 0;
    logic [7:0] exp_q [$];
    int         start_q [$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Frame decoder: start detected on the first low sample, bits sampled mid-period.
    int         mon_st;
    logic [7:0] mon_b;
    logic       mon_ok, mon_start, mon_stop;
    logic [7:0] mon_exp;
    always begin
        @(negedge clock);
        if (!reset && tx === 1'b0) begin
            mon_st = cyc;
            mon_b  = '0;
            mon_ok = 1'b1;
            mon_start = 1'b0;
            mon_stop  = 1'b0;
            for (int i = 1; i < 10 * CPB && mon_ok; i++) begin
                @(negedge clock);
                if (reset)
                    mon_ok = 1'b0;
                else if (i == CPB / 2)
                    mon_start = tx;
                else if (i >= CPB + CPB / 2 && i < 9 * CPB && (i - CPB / 2) % CPB == 0)
                    mon_b[(i - CPB - CPB / 2) / CPB] = tx;
                else if (i == 9 * CPB + CPB / 2)
                    mon_stop = tx;
            end
            if (mon_ok) begin
                frames++;
                start_q.push_back(mon_st);
                chk("start_bit", mon_start, 1'b0);
                chk("stop_bit", mon_stop, 1'b1);
                chk("sb_nonempty", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    mon_exp = exp_q.pop_front();
                    chk("rx_byte", mon_b, mon_exp);
                end
            end
        end
    end

    task automatic send(input logic [7:0] b, input bit accept);
        core_bus.out_en   = 1'b1;
        core_bus.out_data = b;
        if (accept)
            exp_q.push_back(b);
        @(negedge clock);
        core_bus.out_en   = 1'b0;
        core_bus.out_data = 8'($urandom);
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        exp_q.delete();
        start_q.delete();
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (busy && n < 2000) begin
            @(negedge clock);
            n++;
        end
        repeat (3) @(negedge clock);
        chk(tag, busy, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int hi;
        int f0;
        logic [9:0] frame;
        logic exp_tx;

        core_bus.out_en   = 1'b0;
        core_bus.out_data = 8'h00;

        // 1: async reset between edges, then idle line
        repeat (2) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("t1_tx", tx, 1'b1);
        chk("t1_busy", busy, 1'b0);
        chk("t1_ovf", overflow, 1'b0);
        chk("t1_count", fifo_count, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        hi = 0;
        repeat (50) begin
            core_bus.out_data = 8'($urandom);
            @(negedge clock);
            hi += int'(tx);
        end
        chk("t1_idle_high", hi, 50);

        // 2: single byte, cycle-exact waveform
        send(8'h41, 1);
        chk("t2_count_push", fifo_count, 1);
        frame = {1'b1, 8'h41, 1'b0};
        for (int k = 0; k < 44; k++) begin
            @(negedge clock);
            if (k == 0)
                chk("t2_count_pop", fifo_count, 0);
            exp_tx = (k < 40) ? frame[k / CPB] : 1'b1;
            chk("t2_tx", tx, exp_tx);
            if (k == 39)
                chk("t2_busy_last", busy, 1'b1);
            if (k == 40)
                chk("t2_busy_done", busy, 1'b0);
        end

        // 3: overflow on six back-to-back strobes
        reset_dut();
        f0 = frames;
        for (int i = 1; i <= 6; i++) begin
            send(8'(i), i <= 5);
            if (i == 5)
                chk("t3_count_full", fifo_count, 4);
            if (i == 6) begin
                chk("t3_count_drop", fifo_count, 4);
                chk("t3_ovf", overflow, 1'b1);
            end
        end
        wait_drain("t3_drain");
        chk("t3_ovf_sticky", overflow, 1'b1);
        chk("t3_frames", frames - f0, 5);
        chk("t3_sb_empty", exp_q.size(), 0);

        // 4: push into a full FIFO on the pop edge
        reset_dut();
        f0 = frames;
        for (int i = 0; i < 5; i++)
            send(8'h10 + 8'(i), 1);
        chk("t4_full", fifo_count, 4);
        repeat (37) @(negedge clock);
        chk("t4_full_before_pop", fifo_count, 4);
        send(8'h7E, 1);
        chk("t4_count_same", fifo_count, 4);
        chk("t4_ovf", overflow, 1'b0);
        wait_drain("t4_drain");
        chk("t4_frames", frames - f0, 6);
        chk("t4_sb_empty", exp_q.size(), 0);

        // 5: inter-frame gap
        reset_dut();
        send(8'h55, 1);
        send(8'hAA, 1);
        wait_drain("t5_drain");
        chk("t5_frames", start_q.size(), 2);
        if (start_q.size() >= 2)
            chk("t5_gap", start_q[1] - start_q[0], 10 * CPB + 1);
        chk("t5_sb_empty", exp_q.size(), 0);

        // 6: reset mid-frame discards the frame and the queue
        reset_dut();
        send(8'h0F, 1);
        send(8'h01, 1);
        send(8'h02, 1);
        chk("t6_queued", fifo_count, 2);
        repeat (16) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("t6_tx", tx, 1'b1);
        chk("t6_count", fifo_count, 0);
        chk("t6_busy", busy, 1'b0);
        exp_q.delete();
        start_q.delete();
        @(negedge clock);
        reset = 1'b0;
        f0 = frames;
        hi = 0;
        repeat (100) begin
            @(negedge clock);
            hi += int'(tx);
        end
        chk("t6_line_high", hi, 100);
        chk("t6_no_frames", frames - f0, 0);
        chk("t6_busy_after", busy, 1'b0);

        chk("final_sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/char_out_uart.md
Name: char_out_uart

Overview:
- Output peripheral on the core's character-out interface (`out_en` / `out_data`).
- The core emits single-cycle `out_en` pulses with no backpressure. This block buffers those bytes in a small FIFO and serialises them as 8N1 UART frames on `tx`.
- Bytes that arrive while the FIFO is full are dropped and flagged.
- Sits at top level between the core and the board TX pin.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (≥2); 434 gives 115200 baud at 50 MHz.
- FIFO_DEPTH, 16, FIFO entries; power of two, ≥2.
- FIFO_AW, $clog2(FIFO_DEPTH), FIFO pointer width; derived, never overridden.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- out_en  input  1  single-cycle strobe from the core: `out_data` is valid this cycle.
- out_data  input  8  character byte from the core.
- tx  output  1  UART serial line, idle high.
- busy  output  1  high while the FIFO is non-empty or a frame is in progress.
- overflow  output  1  sticky: a byte was dropped because the FIFO was full.
- fifo_count  output  FIFO_AW+1  current FIFO occupancy, 0..FIFO_DEPTH.

Behaviour:
- Reset, asynchronous while `reset`=1:
  - Outputs: `tx`=1, `busy`=0, `overflow`=0, `fifo_count`=0.
  - Internal: FIFO pointers 0, FSM in IDLE, baud and bit counters 0.
  - Reset mid-frame aborts the frame: `tx` goes high immediately and all queued bytes are discarded.
- FIFO push, evaluated at each rising edge with `out_en`=1:
  - Accepted if `fifo_count` < FIFO_DEPTH, or if a pop happens on the same edge.
  - Otherwise the byte is dropped and `overflow` is set to 1; it stays 1 until reset.
  - Push and pop on the same edge leave `fifo_count` unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - `fifo_count` updates on the edge that samples the push/pop.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - `tx`=1.
  - If `fifo_count` ≠ 0 at an edge: pop the head into the 8-bit shift register and go to START.
  - A pop cannot occur in the same cycle as the byte's own push. Minimum latency is therefore: `out_en` sampled at edge N, pop at edge N+1, `tx` falls after edge N+1.
- START:
  - `tx`=0 for exactly CLKS_PER_BIT cycles.
  - Then go to DATA with bit index 0.
- DATA:
  - `tx` = shift register bit 0 (LSB first).
  - Each bit is held CLKS_PER_BIT cycles, then the register shifts right.
  - After bit index 7 completes, go to STOP.
- STOP:
  - `tx`=1 for CLKS_PER_BIT cycles, then go to IDLE.
  - The IDLE cycle always intervenes, so consecutive frames are separated by exactly one extra high cycle (stop length CLKS_PER_BIT+1).
- `tx` is driven from a register (glitch-free).
- The baud counter counts 0..CLKS_PER_BIT-1 and resets at each bit boundary.
- `busy` = (state ≠ IDLE) | (`fifo_count` ≠ 0), registered-consistent with state and count.
- `out_data` is ignored when `out_en`=0.
- `overflow` does not block further pushes once space frees up.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
1. Assert `reset` asynchronously between edges → `tx`=1, `busy`=0, `overflow`=0, `fifo_count`=0 immediately. Release with `out_en`=0 for 50 cycles → `tx` stays 1.
2. Single pulse `out_en`=1, `out_data`=0x41 at edge N:
   - `fifo_count`=1 after edge N, 0 after edge N+1.
   - `tx` sequence from edge N+1: 0 ×4, then 1,0,0,0,0,0,1,0 each ×4, then 1 ×4.
   - `busy` falls after the 40-cycle frame.
3. Six consecutive pulses 0x01..0x06 on an idle block:
   - `fifo_count` reaches 4.
   - 0x06 is dropped and `overflow`=1.
   - Serial output decodes exactly 0x01,0x02,0x03,0x04,0x05; `overflow` remains 1 afterwards.
4. Fill FIFO to 4 during a frame, then time an `out_en` (0x7E) to coincide with the IDLE pop edge → byte accepted, `fifo_count` stays 4, `overflow`=0, 0x7E transmitted last.
5. Back-to-back 0x55 then 0xAA → the second start bit begins exactly 5 cycles after the first stop bit begins (4 stop + 1 IDLE); decoded bytes are 0x55, 0xAA.
6. Assert `reset` during DATA bit 3 of 0x0F with 2 bytes queued → `tx`=1 immediately, `fifo_count`=0, `busy`=0. No further frames after release.
